fm_write_back_ctrl: RTL
=======================

Name: fm_write_back_ctrl

Overview:
- Write-side initiator for the float16 feature-map RAM's parallel write port.
- Accepts PARA_Y*PARA_KERNEL result blocks from the PE array and generates addresses: conv interior with padding offset, or linear for fc.
- Drives ena_para_w / ena_add_write / addr_para_write / fm_out_size / para_din, holding each request until the RAM's write_ready.
- Optionally zero-fills the output map first, so padding cells are 0.

Parameters:
DATA_WIDTH, 16, bits per float16 element
PARA_Y, 3, output pixels per block along x
PARA_KERNEL, 2, kernels per block
WRITE_ADDR_WIDTH, 12, RAM write address width
FM_SIZE_WIDTH, 8, width of feature-map size fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle layer start pulse; ignored unless IDLE
cfg_type  in  1  0 conv, 1 fc
cfg_fm_out_size  in  FM_SIZE_WIDTH  conv: padded map side; fc: output count
cfg_padding  in  4  conv padding
cfg_accumulate  in  1  value driven on ena_add_write
cfg_zero_fill  in  1  zero-fill the map before writing
res_valid  in  1  result block valid
res_ready  out  1  block accepted when res_valid && res_ready
res_data  in  PARA_Y*PARA_KERNEL*DATA_WIDTH  result block
ena_zero_w  out  1  RAM zero-range write request
zero_start_addr  out  WRITE_ADDR_WIDTH  zero range start
zero_end_addr  out  WRITE_ADDR_WIDTH  zero range end, inclusive
ena_para_w  out  1  RAM parallel write request
ena_add_write  out  1  accumulate into existing contents
addr_para_write  out  WRITE_ADDR_WIDTH  block write address
fm_out_size  out  FM_SIZE_WIDTH  registered copy of cfg_fm_out_size
para_din  out  PARA_Y*PARA_KERNEL*DATA_WIDTH  registered block data
write_ready  in  1  RAM: current request complete
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at layer end
cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset state: state IDLE; all outputs, counters and registers 0.
- Reset mid-operation returns to IDLE on the next edge and drops any pending RAM request. The layer must then be restarted by the producer.
- cfg_start sampled in IDLE:
  - All cfg_* values are latched.
  - Conv: W = fm_out_size - 2*padding. If W <= 0, pulse cfg_err, stay IDLE.
  - Conv: W must be a multiple of PARA_Y.
  - fc: fm_out_size = 0 pulses cfg_err.
- Next state after an accepted start: ZERO if cfg_zero_fill, else WAIT_RES.
- ZERO state:
  - ena_zero_w = 1, zero_start_addr = 0.
  - zero_end_addr = fm_out_size*fm_out_size - 1 for conv, fm_out_size - 1 for fc.
  - Held until write_ready is sampled high; then ena_zero_w = 0 next cycle and go to WAIT_RES.
- WAIT_RES state:
  - res_ready = 1.
  - On the accepting handshake, res_data is registered into para_din and the state goes to WRITE.
  - ena_para_w rises on the cycle after the handshake (latency 1).
- WRITE state:
  - ena_para_w = 1; addr, data and ena_add_write are held stable.
  - res_ready = 0. res_valid here is back-pressured and its data is kept by the producer.
  - When write_ready is sampled high, ena_para_w = 0 next cycle. It stays low for at least one cycle before any new request.
  - The address advances. If it was the last block, done pulses and the state goes to IDLE; otherwise to WAIT_RES.
- Conv addressing:
  - row r in [padding, padding+W-1], column c in {0, PARA_Y, ...}.
  - addr = r*fm_out_size + padding + c.
  - c += PARA_Y. When c + PARA_Y >= W: c = 0, r += 1.
  - Last block: r = padding+W-1 and c = W-PARA_Y.
  - First address = padding*(fm_out_size+1), e.g. 9 for padding 1 and size 8.
- fc addressing: addr starts at 0 and increments by PARA_Y*PARA_KERNEL. The layer is done when the next addr >= fm_out_size.
- Multiplies use an internal 2*FM_SIZE_WIDTH width and are truncated to WRITE_ADDR_WIDTH. Wrap beyond that width is a configuration error and is not detected.
- write_ready high outside ZERO/WRITE is ignored.
- write_ready already high on the first request cycle completes that request in that cycle.
- busy = (state != IDLE). done and cfg_err are never simultaneous.

Test Plan:
- conv, fm_out_size 8, padding 1, no zero-fill, RAM ready after 3 cycles, 12 blocks → addresses 9,12,17,20,25,28,33,36,41,44,49,52 in order; ena_add_write = cfg_accumulate; done once after the 12th write_ready; busy then 0.
- zero-fill conv size 8 → ena_zero_w held with range 0..63 until write_ready; no ena_para_w before ena_zero_w falls.
- fc, fm_out_size 6, PARA_Y 3, PARA_KERNEL 2 → single write at addr 0 with para_din equal to the accepted res_data; done next cycle.
- Back-pressure: res_valid held high during WRITE → res_ready 0; the next block is accepted only after write_ready; ena_para_w low at least 1 cycle between requests.
- Errors: cfg_start with size 2, padding 1 → cfg_err pulse, no RAM request. cfg_start while busy → ignored, addresses unaffected.
- Assert rst during the 5th WRITE → next cycle all outputs 0, state IDLE; a fresh start restarts at addr 9.

Source files
------------

// File: rtl/fm_write_back_ctrl_if.sv
// Result-block handshake plus the feature-map RAM's parallel write port.
// The master modport is the write-back controller; slave is the PE array / RAM side.
interface fm_write_back_ctrl_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int PARA_Y           = 3,
    parameter int PARA_KERNEL      = 2,
    parameter int WRITE_ADDR_WIDTH = 12,
    parameter int FM_SIZE_WIDTH    = 8
);
    localparam int BW = PARA_Y * PARA_KERNEL * DATA_WIDTH;

    logic                        res_valid;
    logic                        res_ready;
    logic [BW-1:0]               res_data;
    logic                        ena_zero_w;
    logic [WRITE_ADDR_WIDTH-1:0] zero_start_addr;
    logic [WRITE_ADDR_WIDTH-1:0] zero_end_addr;
    logic                        ena_para_w;
    logic                        ena_add_write;
    logic [WRITE_ADDR_WIDTH-1:0] addr_para_write;
    logic [FM_SIZE_WIDTH-1:0]    fm_out_size;
    logic [BW-1:0]               para_din;
    logic                        write_ready;

    modport master (
        input  res_valid, res_data, write_ready,
        output res_ready, ena_zero_w, zero_start_addr, zero_end_addr,
               ena_para_w, ena_add_write, addr_para_write, fm_out_size, para_din
    );

    modport slave (
        output res_valid, res_data, write_ready,
        input  res_ready, ena_zero_w, zero_start_addr, zero_end_addr,
               ena_para_w, ena_add_write, addr_para_write, fm_out_size, para_din
    );
endinterface

// File: rtl/fm_write_back_ctrl.sv
// Write-back controller: optional zero-fill of the output map, then one RAM
// write per accepted PE result block at conv-interior or linear fc addresses.
module fm_write_back_ctrl #(
    parameter int DATA_WIDTH       = 16,
    parameter int PARA_Y           = 3,
    parameter int PARA_KERNEL      = 2,
    parameter int WRITE_ADDR_WIDTH = 12,
    parameter int FM_SIZE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_type,
    input  logic [FM_SIZE_WIDTH-1:0] cfg_fm_out_size,
    input  logic [3:0]               cfg_padding,
    input  logic                     cfg_accumulate,
    input  logic                     cfg_zero_fill,
    fm_write_back_ctrl_if.master     bus,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);
    localparam int FW = FM_SIZE_WIDTH;
    localparam int MW = 2 * FM_SIZE_WIDTH;
    localparam int AW = WRITE_ADDR_WIDTH;
    localparam int BW = PARA_Y * PARA_KERNEL * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ZERO, WAIT_RES, WRITE} state_t;

    state_t          state_q, state_d;
    logic            type_q, type_d;
    logic            acc_q, acc_d;
    logic [FW-1:0]   size_q, size_d;
    logic [FW-1:0]   w_q, w_d;
    logic [FW-1:0]   r_q, r_d;
    logic [3:0]      pad_q, pad_d;
    logic [MW-1:0]   c_q, c_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   zero_end_q, zero_end_d;
    logic [BW-1:0]   din_q, din_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [FW:0]     w_cfg;
    logic [FW-1:0]   w_mod;
    logic            start_bad;
    logic            last_blk;
    logic            row_wrap;
    logic [MW-1:0]   fc_next;

    // fc uses the column counter as the linear element index.
    function automatic logic [AW-1:0] calc_addr(input logic t, input logic [FW-1:0] sz,
                                                 input logic [3:0] pd, input logic [FW-1:0] r,
                                                 input logic [MW-1:0] c);
        logic [MW-1:0] a;
        if (t) a = c;
        else   a = MW'(r) * MW'(sz) + MW'(pd) + c;
        return AW'(a);
    endfunction

    // Interior width carries a sign bit so padding that eats the whole map is caught.
    assign w_cfg     = {1'b0, cfg_fm_out_size} - (FW + 1)'({cfg_padding, 1'b0});
    assign w_mod     = w_cfg[FW-1:0] % FW'(PARA_Y);
    assign start_bad = cfg_type ? (cfg_fm_out_size == '0)
                                : (w_cfg[FW] || (w_cfg == '0) || (w_mod != '0));

    assign fc_next  = c_q + MW'(PARA_Y * PARA_KERNEL);
    assign row_wrap = (c_q + MW'(PARA_Y)) >= MW'(w_q);
    assign last_blk = type_q ? (fc_next >= MW'(size_q))
                             : ((r_q == FW'(pad_q) + w_q - FW'(1)) &&
                                (c_q == MW'(w_q) - MW'(PARA_Y)));

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        acc_d      = acc_q;
        size_d     = size_q;
        w_d        = w_q;
        r_d        = r_q;
        pad_d      = pad_q;
        c_d        = c_q;
        addr_d     = addr_q;
        zero_end_d = zero_end_q;
        din_d      = din_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    type_d = cfg_type;
                    size_d = cfg_fm_out_size;
                    pad_d  = cfg_padding;
                    acc_d  = cfg_accumulate;
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        w_d        = cfg_type ? '0 : w_cfg[FW-1:0];
                        r_d        = cfg_type ? '0 : FW'(cfg_padding);
                        c_d        = '0;
                        addr_d     = calc_addr(cfg_type, cfg_fm_out_size, cfg_padding, r_d, '0);
                        zero_end_d = cfg_type ? AW'(MW'(cfg_fm_out_size) - MW'(1))
                                              : AW'(MW'(cfg_fm_out_size) * MW'(cfg_fm_out_size) - MW'(1));
                        state_d    = cfg_zero_fill ? ZERO : WAIT_RES;
                    end
                end
            end
            ZERO: begin
                if (bus.write_ready) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (bus.res_valid) begin
                    din_d   = bus.res_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.write_ready) begin
                    if (last_blk) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (type_q) begin
                            c_d = fc_next;
                        end else if (row_wrap) begin
                            c_d = '0;
                            r_d = r_q + FW'(1);
                        end else begin
                            c_d = c_q + MW'(PARA_Y);
                        end
                        addr_d  = calc_addr(type_q, size_q, pad_q, r_d, c_d);
                        state_d = WAIT_RES;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            type_q     <= 1'b0;
            acc_q      <= 1'b0;
            size_q     <= '0;
            w_q        <= '0;
            r_q        <= '0;
            pad_q      <= '0;
            c_q        <= '0;
            addr_q     <= '0;
            zero_end_q <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            acc_q      <= acc_d;
            size_q     <= size_d;
            w_q        <= w_d;
            r_q        <= r_d;
            pad_q      <= pad_d;
            c_q        <= c_d;
            addr_q     <= addr_d;
            zero_end_q <= zero_end_d;
            din_q      <= din_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.res_ready       = (state_q == WAIT_RES);
    assign bus.ena_zero_w      = (state_q == ZERO);
    assign bus.zero_start_addr = '0;
    assign bus.zero_end_addr   = zero_end_q;
    assign bus.ena_para_w      = (state_q == WRITE);
    assign bus.ena_add_write   = acc_q;
    assign bus.addr_para_write = addr_q;
    assign bus.fm_out_size     = size_q;
    assign bus.para_din        = din_q;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign cfg_err             = err_q;
endmodule
